// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// rr_arbiter: round-robin arbiter feeding the mux priority selector.
// Arbitrates PORT_NUM requesters and holds a registered one-hot grant that
// steers exactly one lane through the downstream mux.
//
// Optional feature macro: RR_ARB_PKT_LOCK_EN
//   defined   - a grant is held until the handshake beat carrying last_i[w]
//   undefined - every handshake releases the grant (beat-level round robin)
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   req_i    per-port request (source valid)
//   last_i   per-port end-of-packet flag, sampled in the handshake cycle
//   ready_i  downstream ready for the muxed beat
//   grant_o  registered one-hot grant (or zero), drives mux.ctrl_i
//   valid_o  muxed beat valid, |(grant_o & req_i)
//   ack_o    per-port ready, grant_o & {PORT_NUM{ready_i}}
//   busy_o   high while a grant is held
module rr_arbiter #(
  parameter int unsigned PORT_NUM = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [PORT_NUM-1:0] last_i,
  input  logic                ready_i,
  output logic [PORT_NUM-1:0] grant_o,
  output logic                valid_o,
  output logic [PORT_NUM-1:0] ack_o,
  output logic                busy_o
);

  localparam int unsigned PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;

  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    ptr_adv;
  logic [PTR_W-1:0]    arb_ptr;
  logic [PORT_NUM-1:0] req_rot;
  logic [PORT_NUM-1:0] pick_rot;
  logic [PORT_NUM-1:0] arb_grant;
  logic                handshake;
  logic                hs_release;
  logic                withdraw;

  // Outputs derived from the registered grant; no added latency.
  assign grant_o = grant_q;
  assign valid_o = |(grant_q & req_i);
  assign ack_o   = grant_q & {PORT_NUM{ready_i}};
  assign busy_o  = (state_q == ST_GRANT);

  assign handshake = valid_o & ready_i;
  // With a grant held, the granted request dropping is exactly valid_o low.
  assign withdraw  = ~valid_o;

`ifdef RR_ARB_PKT_LOCK_EN
  assign hs_release = handshake & (|(grant_q & last_i));
`else
  assign hs_release = handshake;
  logic unused_last;
  assign unused_last = ^last_i;
`endif

  // Index of the currently granted port.
  always_comb begin : win_enc
    win_idx = '0;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      if (grant_q[i]) win_idx = PTR_W'(i);
    end
  end

  assign ptr_adv = PTR_W'((32'(win_idx) + 32'd1) % 32'(PORT_NUM));

  // From IDLE arbitrate from ptr; in GRANT re-arbitrate from the advanced
  // pointer so a release edge can hand over with no idle bubble.
  assign arb_ptr = (state_q == ST_GRANT) ? ptr_adv : ptr_q;

  // Rotate requests so arb_ptr sits at bit 0, isolate the lowest set bit,
  // then rotate the pick back into port order.
  always_comb begin : arb
    req_rot   = PORT_NUM'({req_i, req_i} >> arb_ptr);
    pick_rot  = req_rot & (~req_rot + PORT_NUM'(1));
    arb_grant = PORT_NUM'(({pick_rot, pick_rot} << arb_ptr) >> PORT_NUM);
  end

  // Next-state: handshake release beats withdrawal when both apply.
  always_comb begin : nxt
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_d = arb_grant;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (hs_release) begin
          ptr_d   = ptr_adv;
          grant_d = arb_grant;
          state_d = (|arb_grant) ? ST_GRANT : ST_IDLE;
        end else if (withdraw) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for rr_arbiter (PORT_NUM=4): directed scenarios
// followed by randomized traffic, all checked against an index-based model.
module tb_rr_arbiter;

  localparam int unsigned N = 4;

  logic         clk_i;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic [N-1:0] last_i;
  logic         ready_i;
  logic [N-1:0] grant_o;
  logic         valid_o;
  logic [N-1:0] ack_o;
  logic         busy_o;

  int n_chk = 0;
  int n_err = 0;

  // Model state: granted port index (-1 = none) and round-robin pointer.
  int m_w;
  int m_ptr;

  rr_arbiter #(.PORT_NUM(N)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .last_i  (last_i),
    .ready_i (ready_i),
    .grant_o (grant_o),
    .valid_o (valid_o),
    .ack_o   (ack_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (p + k) % int'(N);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_w >= 0) g[m_w] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_w   = -1;
    m_ptr = 0;
  endtask

  task automatic model_step();
    logic ended;
    if (rst_i) begin
      model_reset();
    end else if (m_w < 0) begin
      if (req_i != '0) m_w = pick(req_i, m_ptr);
    end else begin
`ifdef RR_ARB_PKT_LOCK_EN
      ended = req_i[m_w] && ready_i && last_i[m_w];
`else
      ended = req_i[m_w] && ready_i;
`endif
      if (ended) begin
        m_ptr = (m_w + 1) % int'(N);
        m_w   = pick(req_i, m_ptr);
      end else if (!req_i[m_w]) begin
        m_w = -1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    req_i   = r;
    last_i  = l;
    ready_i = rd;
  endtask

  task automatic sample();
    logic [N-1:0] eg;
    @(negedge clk_i);
    eg = exp_grant();
    chk("grant", 32'(grant_o), 32'(eg));
    chk("valid", 32'(valid_o), 32'(|(eg & req_i)));
    chk("ack",   32'(ack_o),   32'(eg & {N{ready_i}}));
    chk("busy",  32'(busy_o),  32'(m_w >= 0));
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  logic [N-1:0] fair_seq [5];
  logic [N-1:0] pkt_seq  [4];
  logic [N-1:0] pkt_last [3];

  initial begin
    fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef RR_ARB_PKT_LOCK_EN
    pkt_seq  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
    pkt_seq  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
`endif
    pkt_last = '{4'b0100, 4'b0100, 4'b0110};

    // Reset state
    rst_i = 1'b1;
    drive('0, '0, 1'b0);
    model_reset();
    sample();
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_busy",  32'(busy_o),  32'd0);
    advance();
    rst_i = 1'b0;

    // Async reset in the middle of a handshake on port 2
    drive(4'b0100, 4'b0000, 1'b1);
    cyc();
    sample();
    chk("mid_grant", 32'(grant_o), 32'b0100);
    chk("mid_ack",   32'(ack_o),   32'b0100);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_now_grant", 32'(grant_o), 32'd0);
    chk("rst_now_valid", 32'(valid_o), 32'd0);
    chk("rst_now_ack",   32'(ack_o),   32'd0);
    chk("rst_now_busy",  32'(busy_o),  32'd0);
    model_reset();
    advance();
    rst_i = 1'b0;
    drive(4'b1111, 4'b0000, 1'b0);
    cyc();
    sample();
    chk("ptr0_after_rst", 32'(grant_o), 32'b0001);
    drive('0, '0, 1'b0);
    advance();
    cyc();

    // Single request on port 2, then pointer lands on 3
    drive(4'b0100, 4'b0100, 1'b1);
    cyc();
    drive(4'b1101, 4'b0100, 1'b1);
    sample();
    chk("single_grant", 32'(grant_o), 32'b0100);
    chk("single_valid", 32'(valid_o), 32'd1);
    chk("single_ack",   32'(ack_o),   32'b0100);
    advance();
    sample();
    chk("single_ptr3", 32'(grant_o), 32'b1000);

    // Fairness under full load
    drive(4'b1111, 4'b1111, 1'b1);
    advance();
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("fair_seq", 32'(grant_o), 32'(fair_seq[k]));
      if (k < 4) advance();
    end
    drive('0, '0, 1'b0);
    advance();

    // Backpressure
    drive(4'b0011, 4'b0011, 1'b0);
    cyc();
    repeat (3) begin
      sample();
      chk("bp_hold", 32'(grant_o), 32'b0001);
      chk("bp_ack0", 32'(ack_o),   32'd0);
      advance();
    end
    ready_i = 1'b1;
    sample();
    chk("bp_ack_go", 32'(ack_o), 32'b0001);
    advance();
    sample();
    chk("bp_next", 32'(grant_o), 32'b0010);
    drive('0, '0, 1'b0);
    advance();

    // Packet lock: port 1 sends 3 beats while port 2 waits
    drive(4'b0110, pkt_last[0], 1'b1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      last_i = pkt_last[k];
      sample();
      chk("pkt_seq", 32'(grant_o), 32'(pkt_seq[k]));
      advance();
    end
    sample();
    chk("pkt_seq", 32'(grant_o), 32'(pkt_seq[3]));
    drive('0, '0, 1'b0);
    advance();

    // Withdrawal on port 3 with port 0 waiting
    drive(4'b1001, 4'b0000, 1'b0);
    cyc();
    sample();
    chk("wd_grant", 32'(grant_o), 32'b1000);
    drive(4'b0001, 4'b0000, 1'b0);
    advance();
    sample();
    chk("wd_idle_grant", 32'(grant_o), 32'd0);
    chk("wd_idle_busy",  32'(busy_o),  32'd0);
    advance();
    sample();
    chk("wd_regrant", 32'(grant_o), 32'b0001);
    drive(4'b0001, 4'b0001, 1'b1);
    advance();

    // Randomized traffic with occasional resets
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_i = 1'b1;
        model_reset();
      end else begin
        rst_i = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) req_i = N'($urandom);
      last_i  = N'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
